pipe_skid_96: RTL and testbench
===============================

PIPE_SKID_96 -- requirements
Module: pipe_skid_96

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and clr.
REQ-002 Port clock, input, 1 bit: rising-edge clock for all state.
REQ-003 Port clr, input, 1 bit: asynchronous active-high reset.
REQ-004 Port in_data, input, 96 bits: producer payload.
REQ-005 Port in_valid, input, 1 bit: producer payload valid.
REQ-006 Port in_ready, output, 1 bit: block can accept a payload this cycle.
REQ-007 Port out_data, output, 96 bits: payload presented to the consumer.
REQ-008 Port out_valid, output, 1 bit: out_data is valid.
REQ-009 Port out_ready, input, 1 bit: consumer takes the payload this cycle.
REQ-010 Port flush, input, 1 bit: synchronous discard of all held entries.
REQ-011 Port occupancy, output, 2 bits: number of held entries (0..2).

Function
REQ-012 Accept SHALL occur when in_valid&in_ready at a rising edge; take SHALL occur when out_valid&out_ready at a rising edge.
REQ-013 Storage SHALL be a 96-bit main register feeding out_data plus a 96-bit skid register; state SHALL be EMPTY(occ 0), ONE(occ 1, main valid) or FULL(occ 2, main+skid valid).
REQ-014 in_ready SHALL equal (state!=FULL)&~clr, decoded from registered state only; it never depends on out_ready.
REQ-015 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY (except per REQ-023); out_data SHALL be main.
REQ-016 EMPTY: accept -> ONE, main<=in_data; no accept -> EMPTY.
REQ-017 ONE: accept&take -> ONE, main<=in_data; accept only -> FULL, skid<=in_data; take only -> EMPTY; neither -> ONE.
REQ-018 FULL: take -> ONE, main<=skid; no take -> FULL, both registers hold.
REQ-019 Payloads SHALL leave in acceptance order; no payload SHALL be duplicated or dropped except by flush/clr.
REQ-020 flush SHALL take priority over accept and take: next state EMPTY, occupancy 0; a payload accepted or taken in the flush cycle is discarded; register contents need not clear.
REQ-021 Latency (macro undefined) SHALL be exactly 1 cycle from accept to out_valid for an accept in EMPTY; sustained throughput SHALL be 1 payload/cycle when out_ready is held 1.
REQ-022 occupancy SHALL be 0/1/2 for EMPTY/ONE/FULL, registered.

Reset
REQ-023 While clr=1, state SHALL be EMPTY and main, skid, out_data SHALL be 96'h0; out_valid=0, in_ready=0, occupancy=0, all asynchronously.
REQ-024 After clr deasserts, in_ready SHALL be 1 in the same cycle; no handshake SHALL complete on an edge where clr=1.
REQ-025 clr mid-operation SHALL discard all held payloads with no partial output.

Configuration
REQ-026 Macro PIPE_SKID_BYPASS_EN SHALL select zero-latency bypass when defined.
REQ-027 With PIPE_SKID_BYPASS_EN defined, in EMPTY: out_valid=in_valid, out_data=in_data combinationally; accept&out_ready -> stays EMPTY (payload passes through); accept&~out_ready -> ONE, main<=in_data; flush still discards.
REQ-028 Without PIPE_SKID_BYPASS_EN, REQ-015/REQ-021 apply unchanged and no input-to-output combinational path exists.

Verification
REQ-029 Reset: clr=1 mid-stream with occ=2 -> out_valid=0, occupancy=0, out_data=96'h0 immediately; clr=0 -> in_ready=1.
REQ-030 Streaming: out_ready=1, accept A,B,C (96'h1,96'h2,96'h3) on consecutive cycles -> out_data 1,2,3 on consecutive cycles starting 1 cycle after A, occupancy stays 1.
REQ-031 Backpressure: out_ready=0, offer 96'hA then 96'hB then 96'hC -> A,B accepted, occupancy=2, in_ready=0, C held by producer; out_ready=1 -> A, B, C emerge in order.
REQ-032 Flush: occupancy=2 with A,B, flush=1 together with in_valid (96'hD) -> next cycle occupancy=0, out_valid=0; D never appears.
REQ-033 FULL take: occupancy=2 (A,B), out_ready pulsed 1 cycle -> A taken, out_data=B, occupancy=1, in_ready=1.
REQ-034 Bypass build: EMPTY, in_valid=1, in_data=96'h5, out_ready=1 -> out_valid=1, out_data=96'h5 same cycle, occupancy remains 0.

Source files
------------

// File: rtl/pipe_skid_96.sv
// Two-entry skid buffer for 96-bit payloads: a main register drives the consumer, a skid register absorbs one extra beat.
// Optional zero-latency pass-through from an empty buffer when PIPE_SKID_BYPASS_EN is defined.
module pipe_skid_96 (
  input  logic        clock,
  input  logic        clr,
  input  logic [95:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [95:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush,
  output logic [1:0]  occupancy
);

  localparam int unsigned W = 96;

  // Encoding equals the entry count so occupancy is a direct register read.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           accept_c;
  logic           take_c;

  assign in_ready  = (state_q != ST_FULL) & ~clr;
  assign occupancy = 2'(state_q);
  assign accept_c  = in_valid & in_ready;
  assign take_c    = out_valid & out_ready;

`ifdef PIPE_SKID_BYPASS_EN
  logic bypass_c;
  assign bypass_c  = (state_q == ST_EMPTY);
  assign out_valid = bypass_c ? (in_valid & ~clr) : 1'b1;
  assign out_data  = bypass_c ? (clr ? W'(0) : in_data) : main_q;
`else
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
`endif

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Flush overrides every handshake; data registers are left as they are.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
`ifdef PIPE_SKID_BYPASS_EN
          if (accept_c && !out_ready) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
`else
          if (accept_c) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
`endif
        end
        ST_ONE: begin
          if (accept_c && take_c) begin
            main_d = in_data;
          end else if (accept_c) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (take_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take_c) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_96.sv
// Self-checking bench for pipe_skid_96: directed vector table, reset/bypass sequences, and
// randomized traffic checked against a queue-based model of a two-entry FIFO.
module tb_pipe_skid_96;

  localparam int unsigned W = 96;

  logic         clock = 1'b0;
  logic         clr;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         flush;
  logic [1:0]   occupancy;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] mq[$];

  pipe_skid_96 dut (
    .clock     (clock),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         fl;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         exp_ov;
    logic         exp_ir;
    logic [1:0]   exp_occ;
    logic         chk_data;
    logic [W-1:0] exp_od;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [W-1:0] d,
                              input logic ordy, input logic ov, input logic ir,
                              input logic [1:0] occ, input logic cd, input logic [W-1:0] od);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.exp_ov = ov; v.exp_ir = ir; v.exp_occ = occ; v.chk_data = cd; v.exp_od = od;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the buffer is an ordered queue holding at most two payloads.
  task automatic model_compare(input string tag);
    logic         exp_ov;
    logic [W-1:0] exp_od;
    exp_ov = (mq.size() > 0);
    exp_od = (mq.size() > 0) ? mq[0] : '0;
`ifdef PIPE_SKID_BYPASS_EN
    if (mq.size() == 0) begin
      exp_ov = in_valid;
      exp_od = in_data;
    end
`endif
    check({tag, "_ir"}, W'(in_ready), W'(mq.size() < 2));
    check({tag, "_ov"}, W'(out_valid), W'(exp_ov));
    check({tag, "_occ"}, W'(occupancy), W'(mq.size()));
    if (exp_ov) check({tag, "_od"}, out_data, exp_od);
  endtask

  task automatic model_step();
    logic was_empty, acc, tk;
    was_empty = (mq.size() == 0);
    acc = in_valid && (mq.size() < 2);
`ifdef PIPE_SKID_BYPASS_EN
    tk = out_ready && (!was_empty || in_valid);
`else
    tk = out_ready && !was_empty;
`endif
    if (flush) begin
      mq.delete();
    end else begin
      if (tk && !was_empty) void'(mq.pop_front());
      if (acc && !(was_empty && tk)) mq.push_back(in_data);
    end
  endtask

  initial begin
    clr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    vecs[0]  = mk(0, 1, 96'h1, 1, 1, 1, 2'd1, 1, 96'h1);
    vecs[1]  = mk(0, 1, 96'h2, 1, 1, 1, 2'd1, 1, 96'h2);
    vecs[2]  = mk(0, 1, 96'h3, 1, 1, 1, 2'd1, 1, 96'h3);
    vecs[3]  = mk(0, 0, 96'h0, 1, 0, 1, 2'd0, 0, 96'h0);
    vecs[4]  = mk(0, 1, 96'hA, 0, 1, 1, 2'd1, 1, 96'hA);
    vecs[5]  = mk(0, 1, 96'hB, 0, 1, 0, 2'd2, 1, 96'hA);
    vecs[6]  = mk(0, 1, 96'hC, 0, 1, 0, 2'd2, 1, 96'hA);
    vecs[7]  = mk(0, 1, 96'hC, 1, 1, 1, 2'd1, 1, 96'hB);
    vecs[8]  = mk(0, 1, 96'hC, 1, 1, 1, 2'd1, 1, 96'hC);
    vecs[9]  = mk(0, 0, 96'h0, 1, 0, 1, 2'd0, 0, 96'h0);
    vecs[10] = mk(0, 1, 96'hA, 0, 1, 1, 2'd1, 1, 96'hA);
    vecs[11] = mk(0, 1, 96'hB, 0, 1, 0, 2'd2, 1, 96'hA);
    vecs[12] = mk(0, 0, 96'h0, 1, 1, 1, 2'd1, 1, 96'hB);
    vecs[13] = mk(0, 1, 96'hC, 0, 1, 0, 2'd2, 1, 96'hB);
    vecs[14] = mk(1, 1, 96'hD, 0, 0, 1, 2'd0, 0, 96'h0);
    vecs[15] = mk(0, 0, 96'h0, 1, 0, 1, 2'd0, 0, 96'h0);

    // Reset state while clr is held.
    #2;
    check("rst_ov", W'(out_valid), W'(0));
    check("rst_ir", W'(in_ready), W'(0));
    check("rst_occ", W'(occupancy), W'(0));
    check("rst_od", out_data, W'(0));
    @(negedge clock);
    clr = 1'b0;
    #1;
    check("rst_rel_ir", W'(in_ready), W'(1));

`ifndef PIPE_SKID_BYPASS_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      flush = vecs[i].fl; in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_ov", i), W'(out_valid), W'(vecs[i].exp_ov));
      check($sformatf("vec%0d_ir", i), W'(in_ready), W'(vecs[i].exp_ir));
      check($sformatf("vec%0d_occ", i), W'(occupancy), W'(vecs[i].exp_occ));
      if (vecs[i].chk_data) check($sformatf("vec%0d_od", i), out_data, vecs[i].exp_od);
    end
`else
    // Zero-latency pass-through from empty.
    @(negedge clock);
    in_valid = 1'b1; in_data = 96'h5; out_ready = 1'b1; flush = 1'b0;
    #1;
    check("byp_ov", W'(out_valid), W'(1));
    check("byp_od", out_data, 96'h5);
    check("byp_occ", W'(occupancy), W'(0));
    @(posedge clock);
    #1;
    check("byp_occ_after", W'(occupancy), W'(0));
`endif

    // clr in the middle of a full buffer.
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b1; in_data = 96'hA; out_ready = 1'b0;
    @(negedge clock);
    in_data = 96'hB;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    check("mid_full_occ", W'(occupancy), W'(2));
    clr = 1'b1;
    in_valid = 1'b1; in_data = 96'hE; out_ready = 1'b1;
    #1;
    check("mid_clr_ov", W'(out_valid), W'(0));
    check("mid_clr_occ", W'(occupancy), W'(0));
    check("mid_clr_od", out_data, W'(0));
    check("mid_clr_ir", W'(in_ready), W'(0));
    @(posedge clock);
    #1;
    check("mid_clr_edge_occ", W'(occupancy), W'(0));
    @(negedge clock);
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("mid_rel_ir", W'(in_ready), W'(1));
    check("mid_rel_ov", W'(out_valid), W'(0));

    // Randomized traffic against the queue model.
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(20) == 0);
      in_data   = {$urandom(), $urandom(), $urandom()};
      #1;
      model_compare($sformatf("rnd%0d", c));
      model_step();
    end

    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
